// File: rtl/mem_write_back.sv
// Write-back stage: retires reg/branch results, performs load/store
// accesses over a valid/ready memory port, and drives rd and PC redirect.
module mem_write_back #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iOpValid,
    output logic              oOpReady,
    input  logic [1:0]        iOpKind,
    input  logic [REG_AW-1:0] iRd,
    input  logic [XLEN-1:0]   iResult,
    input  logic [XLEN-1:0]   iStoreData,
    input  logic [2:0]        iFunct3,
    input  logic              iBranchTaken,
    input  logic [XLEN-1:0]   iBranchTarget,
    input  logic [XLEN-1:0]   iLinkPc,
    output logic              oMemValid,
    input  logic              iMemReady,
    output logic              oMemWe,
    output logic [XLEN-1:0]   oMemAddr,
    output logic [XLEN-1:0]   oMemWData,
    output logic [3:0]        oMemBe,
    input  logic              iMemRValid,
    input  logic [XLEN-1:0]   iMemRData,
    output logic              oRdWe,
    output logic [REG_AW-1:0] oRdAddr,
    output logic [XLEN-1:0]   oRdData,
    output logic              oPcLoad,
    output logic [XLEN-1:0]   oPcTarget,
    output logic              oMisaligned
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT
    } state_t;

    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd2;
    localparam logic [1:0] KIND_BRANCH = 2'd3;

    state_t              state;
    logic [2:0]          ldFunct3;
    logic [1:0]          ldOff;
    logic [REG_AW-1:0]   ldRd;
    logic                misaligned;
    logic [3:0]          reqBe;
    logic [XLEN-1:0]     reqWData;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     loadVal;

    assign oOpReady = (state == IDLE);

    // Unknown size encodings are rejected through the misaligned path
    always_comb begin
        misaligned = 1'b0;
        case (iFunct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = iResult[0];
            3'b010:         misaligned = |iResult[1:0];
            default:        misaligned = 1'b1;
        endcase
    end

    always_comb begin
        reqBe    = 4'b1111;
        reqWData = iStoreData;
        case (iFunct3[1:0])
            2'b00: begin
                reqBe    = 4'b0001 << iResult[1:0];
                reqWData = {(XLEN/8){iStoreData[7:0]}};
            end
            2'b01: begin
                reqBe    = iResult[1] ? 4'b1100 : 4'b0011;
                reqWData = {(XLEN/16){iStoreData[15:0]}};
            end
            default: begin
                reqBe    = 4'b1111;
                reqWData = iStoreData;
            end
        endcase
    end

    assign shifted = iMemRData >> {ldOff, 3'b000};

    always_comb begin
        loadVal = shifted;
        case (ldFunct3)
            3'b000:  loadVal = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  loadVal = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  loadVal = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  loadVal = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: loadVal = shifted;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state       <= IDLE;
            oMemValid   <= 1'b0;
            oMemWe      <= 1'b0;
            oMemAddr    <= '0;
            oMemWData   <= '0;
            oMemBe      <= '0;
            oRdWe       <= 1'b0;
            oRdAddr     <= '0;
            oRdData     <= '0;
            oPcLoad     <= 1'b0;
            oPcTarget   <= '0;
            oMisaligned <= 1'b0;
            ldFunct3    <= '0;
            ldOff       <= '0;
            ldRd        <= '0;
        end else begin
            oRdWe       <= 1'b0;
            oPcLoad     <= 1'b0;
            oMisaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (iOpValid) begin
                        case (iOpKind)
                            KIND_REG: begin
                                oRdWe   <= |iRd;
                                oRdAddr <= iRd;
                                oRdData <= iResult;
                            end
                            KIND_BRANCH: begin
                                oPcLoad   <= iBranchTaken;
                                oPcTarget <= iBranchTarget;
                                oRdWe     <= |iRd;
                                oRdAddr   <= iRd;
                                oRdData   <= iLinkPc;
                            end
                            default: begin
                                if (misaligned) begin
                                    oMisaligned <= 1'b1;
                                end else begin
                                    state     <= MEM_REQ;
                                    oMemValid <= 1'b1;
                                    oMemWe    <= (iOpKind == KIND_STORE);
                                    oMemAddr  <= {iResult[XLEN-1:2], 2'b00};
                                    oMemBe    <= reqBe;
                                    oMemWData <= reqWData;
                                    ldFunct3  <= iFunct3;
                                    ldOff     <= iResult[1:0];
                                    ldRd      <= iRd;
                                end
                            end
                        endcase
                    end
                end
                MEM_REQ: begin
                    if (iMemReady) begin
                        oMemValid <= 1'b0;
                        state     <= oMemWe ? IDLE : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (iMemRValid) begin
                        oRdWe   <= |ldRd;
                        oRdAddr <= ldRd;
                        oRdData <= loadVal;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_write_back.sv
// Bench for mem_write_back: table of single-cycle ops plus
// load/store and reset sequences checked against a scoreboard queue.
module tb_mem_write_back;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iOpValid;
    logic        oOpReady;
    logic [1:0]  iOpKind;
    logic [4:0]  iRd;
    logic [31:0] iResult;
    logic [31:0] iStoreData;
    logic [2:0]  iFunct3;
    logic        iBranchTaken;
    logic [31:0] iBranchTarget;
    logic [31:0] iLinkPc;
    logic        oMemValid;
    logic        iMemReady;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [3:0]  oMemBe;
    logic        iMemRValid;
    logic [31:0] iMemRData;
    logic        oRdWe;
    logic [4:0]  oRdAddr;
    logic [31:0] oRdData;
    logic        oPcLoad;
    logic [31:0] oPcTarget;
    logic        oMisaligned;

    mem_write_back #(.XLEN(32), .REG_AW(5)) dut (
        .iClk(iClk), .iRst(iRst),
        .iOpValid(iOpValid), .oOpReady(oOpReady),
        .iOpKind(iOpKind), .iRd(iRd), .iResult(iResult),
        .iStoreData(iStoreData), .iFunct3(iFunct3),
        .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .iLinkPc(iLinkPc),
        .oMemValid(oMemValid), .iMemReady(iMemReady),
        .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .oMemBe(oMemBe),
        .iMemRValid(iMemRValid), .iMemRData(iMemRData),
        .oRdWe(oRdWe), .oRdAddr(oRdAddr), .oRdData(oRdData),
        .oPcLoad(oPcLoad), .oPcTarget(oPcTarget),
        .oMisaligned(oMisaligned)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [2:0]  f3;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] link;
        logic        eWe;
        logic [31:0] eData;
        logic        ePc;
        logic        eMis;
    } vec_t;

    vec_t        vt[10];
    vec_t        sb[$];
    logic [31:0] sbLd[$];
    int          nPass = 0;
    int          nChecks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nChecks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else
            nPass++;
    endtask

    task automatic idleInputs();
        iOpValid      = 1'b0;
        iOpKind       = 2'd0;
        iRd           = '0;
        iResult       = '0;
        iStoreData    = '0;
        iFunct3       = '0;
        iBranchTaken  = 1'b0;
        iBranchTarget = '0;
        iLinkPc       = '0;
        iMemReady     = 1'b0;
        iMemRValid    = 1'b0;
        iMemRData     = '0;
    endtask

    task automatic doStore(input string nm, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] data,
                           input logic [31:0] eAddr, input logic [3:0] eBe,
                           input logic [31:0] eWd, input int dly);
        iOpValid = 1'b1; iOpKind = 2'd2; iRd = 5'd9;
        iResult = addr; iFunct3 = f3; iStoreData = data;
        @(negedge iClk);
        iOpValid = 1'b0;
        iStoreData = 32'h0;
        iResult = 32'h0;
        for (int k = 0; k <= dly; k++) begin
            chk({nm, " valid"}, oMemValid, 1'b1);
            chk({nm, " we"}, oMemWe, 1'b1);
            chk({nm, " addr"}, oMemAddr, eAddr);
            chk({nm, " be"}, oMemBe, eBe);
            chk({nm, " wdata"}, oMemWData, eWd);
            chk({nm, " busy"}, oOpReady, 1'b0);
            if (k == dly) iMemReady = 1'b1;
            @(negedge iClk);
        end
        iMemReady = 1'b0;
        chk({nm, " done valid"}, oMemValid, 1'b0);
        chk({nm, " done ready"}, oOpReady, 1'b1);
        chk({nm, " no rd"}, oRdWe, 1'b0);
    endtask

    task automatic doLoad(input string nm, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] rdata,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int rdyDly, input int rvDly);
        logic        got;
        logic [31:0] e;
        iOpValid = 1'b1; iOpKind = 2'd1; iRd = rd;
        iResult = addr; iFunct3 = f3;
        sbLd.push_back(exp);
        @(negedge iClk);
        iOpValid = 1'b0;
        chk({nm, " req valid"}, oMemValid, 1'b1);
        chk({nm, " req we"}, oMemWe, 1'b0);
        chk({nm, " req addr"}, oMemAddr, addr & 32'hFFFF_FFFC);
        repeat (rdyDly) @(negedge iClk);
        iMemReady = 1'b1;
        @(negedge iClk);
        iMemReady = 1'b0;
        chk({nm, " req drop"}, oMemValid, 1'b0);
        for (int k = 0; k < rvDly; k++) begin
            chk({nm, " wait busy"}, oOpReady, 1'b0);
            @(negedge iClk);
        end
        iMemRData = rdata;
        iMemRValid = 1'b1;
        @(negedge iClk);
        iMemRValid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (oRdWe) begin
                got = 1'b1;
                e = sbLd.pop_front();
                chk({nm, " rd addr"}, oRdAddr, rd);
                chk({nm, " rd data"}, oRdData, e);
                chk({nm, " ready"}, oOpReady, 1'b1);
            end else begin
                @(negedge iClk);
            end
        end
        if (!got) begin
            nChecks++;
            $display("FAIL %s timeout: no rd write seen", nm);
            void'(sbLd.pop_front());
        end
        @(negedge iClk);
    endtask

    initial begin
        vec_t e;
        idleInputs();
        vt[0] = '{2'd0, 5'd5,  32'hDEADBEEF, 3'd0, 1'b0, 32'h0,   32'h0,
                  1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        vt[1] = '{2'd0, 5'd0,  32'h12345678, 3'd0, 1'b0, 32'h0,   32'h0,
                  1'b0, 32'h0, 1'b0, 1'b0};
        vt[2] = '{2'd3, 5'd1,  32'h0, 3'd0, 1'b1, 32'h400, 32'h104,
                  1'b1, 32'h104, 1'b1, 1'b0};
        vt[3] = '{2'd3, 5'd1,  32'h0, 3'd0, 1'b0, 32'h800, 32'h108,
                  1'b1, 32'h108, 1'b0, 1'b0};
        vt[4] = '{2'd2, 5'd3,  32'h201, 3'b010, 1'b0, 32'h0, 32'h0,
                  1'b0, 32'h0, 1'b0, 1'b1};
        vt[5] = '{2'd1, 5'd4,  32'h203, 3'b001, 1'b0, 32'h0, 32'h0,
                  1'b0, 32'h0, 1'b0, 1'b1};
        vt[6] = '{2'd1, 5'd4,  32'h0, 3'b011, 1'b0, 32'h0, 32'h0,
                  1'b0, 32'h0, 1'b0, 1'b1};
        vt[7] = '{2'd3, 5'd0,  32'h0, 3'd0, 1'b1, 32'h10, 32'h44,
                  1'b0, 32'h0, 1'b1, 1'b0};
        vt[8] = '{2'd0, 5'd31, 32'h00000001, 3'd0, 1'b0, 32'h0, 32'h0,
                  1'b1, 32'h00000001, 1'b0, 1'b0};
        vt[9] = '{2'd1, 5'd6,  32'h202, 3'b101, 1'b0, 32'h0, 32'h0,
                  1'b0, 32'h0, 1'b0, 1'b0};

        // Reset two cycles
        iRst = 1'b0;
        repeat (2) @(negedge iClk);
        chk("rst ready", oOpReady, 1'b1);
        chk("rst memValid", oMemValid, 1'b0);
        chk("rst memWe", oMemWe, 1'b0);
        chk("rst memAddr", oMemAddr, 32'h0);
        chk("rst memWData", oMemWData, 32'h0);
        chk("rst memBe", oMemBe, 4'h0);
        chk("rst rdWe", oRdWe, 1'b0);
        chk("rst rdAddr", oRdAddr, 5'h0);
        chk("rst rdData", oRdData, 32'h0);
        chk("rst pcLoad", oPcLoad, 1'b0);
        chk("rst pcTarget", oPcTarget, 32'h0);
        chk("rst misaligned", oMisaligned, 1'b0);
        iRst = 1'b1;
        @(negedge iClk);

        // Single-cycle ops, back-to-back; vt[9] is a valid load left aside
        for (int i = 0; i < 9; i++) begin
            iOpValid      = 1'b1;
            iOpKind       = vt[i].kind;
            iRd           = vt[i].rd;
            iResult       = vt[i].res;
            iFunct3       = vt[i].f3;
            iBranchTaken  = vt[i].tk;
            iBranchTarget = vt[i].tgt;
            iLinkPc       = vt[i].link;
            sb.push_back(vt[i]);
            @(negedge iClk);
            e = sb.pop_front();
            chk($sformatf("vec%0d rdWe", i), oRdWe, e.eWe);
            if (e.eWe) begin
                chk($sformatf("vec%0d rdAddr", i), oRdAddr, e.rd);
                chk($sformatf("vec%0d rdData", i), oRdData, e.eData);
            end
            chk($sformatf("vec%0d pcLoad", i), oPcLoad, e.ePc);
            if (e.ePc)
                chk($sformatf("vec%0d pcTarget", i), oPcTarget, e.tgt);
            chk($sformatf("vec%0d mis", i), oMisaligned, e.eMis);
            chk($sformatf("vec%0d memValid", i), oMemValid, 1'b0);
            chk($sformatf("vec%0d ready", i), oOpReady, 1'b1);
        end
        idleInputs();
        @(negedge iClk);
        chk("pulse end rdWe", oRdWe, 1'b0);
        chk("pulse end pcLoad", oPcLoad, 1'b0);
        chk("pulse end mis", oMisaligned, 1'b0);

        // Read data outside MEM_WAIT is ignored
        iMemRValid = 1'b1;
        iMemRData = 32'hFFFF_FFFF;
        @(negedge iClk);
        iMemRValid = 1'b0;
        chk("stray rvalid", oRdWe, 1'b0);

        doStore("stB", 32'h103, 3'b000, 32'h000000A5,
                32'h100, 4'b1000, 32'hA5A5A5A5, 3);
        doStore("stH", 32'h106, 3'b001, 32'h1234ABCD,
                32'h104, 4'b1100, 32'hABCDABCD, 0);
        doStore("stW", 32'h10, 3'b010, 32'hCAFEF00D,
                32'h10, 4'b1111, 32'hCAFEF00D, 1);

        doLoad("ldB", 32'h102, 3'b000, 32'h12F45678, 5'd7,
               32'hFFFFFFF4, 0, 0);
        doLoad("ldBU", 32'h102, 3'b100, 32'h12F45678, 5'd8,
               32'h000000F4, 2, 1);
        doLoad("ldHU", vt[9].res, vt[9].f3, 32'h12F45678, vt[9].rd,
               32'h000012F4, 1, 3);
        doLoad("ldH", 32'h100, 3'b001, 32'h12F48765, 5'd10,
               32'hFFFF8765, 0, 2);
        doLoad("ldW", 32'h104, 3'b010, 32'h89ABCDEF, 5'd11,
               32'h89ABCDEF, 0, 0);
        doLoad("ldB3", 32'h203, 3'b000, 32'h7F000000, 5'd12,
               32'h0000007F, 0, 0);

        // Reset while waiting for load data discards the access
        iOpValid = 1'b1; iOpKind = 2'd1; iRd = 5'd13;
        iResult = 32'h300; iFunct3 = 3'b010;
        @(negedge iClk);
        iOpValid = 1'b0;
        iMemReady = 1'b1;
        @(negedge iClk);
        iMemReady = 1'b0;
        chk("rstw in wait", oOpReady, 1'b0);
        iRst = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        chk("rstw ready", oOpReady, 1'b1);
        chk("rstw memValid", oMemValid, 1'b0);
        iMemRValid = 1'b1;
        iMemRData = 32'h5555AAAA;
        @(negedge iClk);
        iMemRValid = 1'b0;
        chk("rstw no write", oRdWe, 1'b0);
        @(negedge iClk);
        chk("rstw no write2", oRdWe, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
